// File: rtl/wolfram_ca_pkg.sv
// Shared types and helpers for the Wolfram elementary cellular-automaton engine.
package wolfram_ca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int RULE_IDX_L = 2;
    localparam int RULE_IDX_C = 1;
    localparam int RULE_IDX_R = 0;

    function automatic logic rule_lookup(input logic [7:0] rule,
                                         input logic l,
                                         input logic c,
                                         input logic r);
        logic [2:0] idx;
        idx             = '0;
        idx[RULE_IDX_L] = l;
        idx[RULE_IDX_C] = c;
        idx[RULE_IDX_R] = r;
        return rule[idx];
    endfunction

endpackage

// File: rtl/wolfram_ca_row_next.sv
// Combinational next-generation row: every cell looks up the rule with its
// left (higher index), centre and right (lower index) neighbours.
module wolfram_ca_row_next
    import wolfram_ca_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PERIODIC = 1
) (
    input  logic [WIDTH-1:0] i_row,
    input  logic [7:0]       i_rule,
    output logic [WIDTH-1:0] o_next
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            logic w_l;
            logic w_r;

            // Edge cells either wrap around the row or see a constant 0.
            if (gi == WIDTH - 1) begin : g_l_edge
                assign w_l = (PERIODIC != 0) ? i_row[0] : 1'b0;
            end else begin : g_l_inner
                assign w_l = i_row[gi+1];
            end

            if (gi == 0) begin : g_r_edge
                assign w_r = (PERIODIC != 0) ? i_row[WIDTH-1] : 1'b0;
            end else begin : g_r_inner
                assign w_r = i_row[gi-1];
            end

            assign o_next[gi] = rule_lookup(i_rule, w_l, i_row[gi], w_r);
        end
    endgenerate

endmodule

// File: rtl/wolfram_ca_engine.sv
// Rule-programmable elementary CA engine with valid/ready seed and result streams.
// Define WOLFRAM_CA_TRACE_EN to stream every generation instead of only the final row.
module wolfram_ca_engine
    import wolfram_ca_pkg::*;
#(
    parameter int         WIDTH        = 16,
    parameter int         GEN_W        = 8,
    parameter logic [7:0] RULE_DEFAULT = 8'hCE,
    parameter int         PERIODIC     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       cfg_rule,
    input  logic             cfg_rule_we,
    input  logic             seed_valid,
    output logic             seed_ready,
    input  logic [WIDTH-1:0] seed_data,
    input  logic [GEN_W-1:0] seed_gens,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [GEN_W-1:0] gen_count
);

`ifdef WOLFRAM_CA_TRACE_EN
    localparam bit TRACE = 1'b1;
`else
    localparam bit TRACE = 1'b0;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_cells;
    logic [7:0]       r_rule;
    logic [GEN_W-1:0] r_remaining;
    logic [GEN_W-1:0] r_gen_count;
    logic             r_seed_ready;
    logic             r_busy;
    logic             r_out_valid;
    logic             r_out_last;

    logic [WIDTH-1:0] w_next;
    logic             w_step;

    wolfram_ca_row_next #(
        .WIDTH   (WIDTH),
        .PERIODIC(PERIODIC)
    ) u_row_next (
        .i_row (r_cells),
        .i_rule(r_rule),
        .o_next(w_next)
    );

    // In trace mode each intermediate row is a beat, so RUN advances only on a handshake.
    assign w_step = TRACE ? out_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cells      <= '0;
            r_rule       <= RULE_DEFAULT;
            r_remaining  <= '0;
            r_gen_count  <= '0;
            r_seed_ready <= 1'b1;
            r_busy       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cfg_rule_we) begin
                        r_rule <= cfg_rule;
                    end
                    if (seed_valid) begin
                        r_cells      <= seed_data;
                        r_remaining  <= seed_gens;
                        r_gen_count  <= '0;
                        r_seed_ready <= 1'b0;
                        r_busy       <= 1'b1;
                        if (seed_gens != '0) begin
                            r_state     <= RUN;
                            r_out_valid <= TRACE;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_state     <= OUT;
                            r_out_valid <= 1'b1;
                            r_out_last  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_step) begin
                        r_cells     <= w_next;
                        r_gen_count <= r_gen_count + GEN_W'(1);
                        r_remaining <= r_remaining - GEN_W'(1);
                        if (r_remaining == GEN_W'(1)) begin
                            r_state     <= OUT;
                            r_out_valid <= 1'b1;
                            r_out_last  <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_state      <= IDLE;
                        r_out_valid  <= 1'b0;
                        r_out_last   <= 1'b0;
                        r_seed_ready <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_out_valid  <= 1'b0;
                    r_out_last   <= 1'b0;
                    r_seed_ready <= 1'b1;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign seed_ready = r_seed_ready;
    assign busy       = r_busy;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign out_data   = r_cells;
    assign gen_count  = r_gen_count;

endmodule

// File: doc/wolfram_ca_engine.md
Name: wolfram_ca_engine

Overview:
Parametrised elementary cellular-automaton engine. It holds a WIDTH-cell row and applies a programmable 3-input Wolfram rule (8-bit truth table) to every cell at once, one generation per clock. It is the sequential, multi-cell, rule-programmable successor of the fixed single-rule 3-input logic blocks in the Wolfram benchmark set. It sits between a seed/config source and a result consumer, using valid/ready streams on both sides.

Parameters:
WIDTH, 16, number of cells (>=3).
GEN_W, 8, width of the generation-count input and counter.
RULE_DEFAULT, 8'hCE, rule register value after reset.
PERIODIC, 1, 1 = wrap-around boundary; 0 = null boundary (out-of-range neighbours read 0).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cfg_rule  input  8  new rule value.
cfg_rule_we  input  1  rule write strobe.
seed_valid  input  1  seed offered.
seed_ready  output  1  engine can accept a seed.
seed_data  input  WIDTH  initial row; bit WIDTH-1 is the leftmost cell.
seed_gens  input  GEN_W  number of generations to run.
busy  output  1  high in RUN or OUT.
out_valid  output  1  result row valid.
out_ready  input  1  consumer accepts.
out_data  output  WIDTH  row.
out_last  output  1  row is the final generation.
gen_count  output  GEN_W  generations completed for the current job.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cells=0, rule=RULE_DEFAULT, gen_count=0.
  - seed_ready=1, busy=0, out_valid=0, out_last=0, out_data=0.
- Next-state rule: next[i] = rule[{L,C,R}].
  - C=cell[i], L=cell[i+1], R=cell[i-1].
  - PERIODIC=1: indices wrap modulo WIDTH.
  - PERIODIC=0: L of cell WIDTH-1 and R of cell 0 read 0.
  - All cells update in the same cycle from the old row.
- Rule write: cfg_rule_we in IDLE loads rule on that edge. A write in any other state is dropped; the rule is stable for a whole job.
  - Same-cycle cfg_rule_we and seed accept: the write takes effect and the job uses the new rule.
- FSM states: IDLE, RUN, OUT.
  - IDLE: seed_ready=1. On seed_valid&&seed_ready: cells<=seed_data, remaining<=seed_gens, gen_count<=0. Go to RUN if seed_gens!=0, otherwise go to OUT.
  - RUN: each cycle apply one generation, gen_count+=1, remaining-=1. When remaining reaches 0, go to OUT. RUN lasts exactly seed_gens cycles, so out_valid rises seed_gens+1 cycles after the accept edge.
  - OUT: out_valid=1, out_data=cells, out_last=1. Hold all outputs stable until out_ready, then go to IDLE.
- seed_ready=0 whenever state is not IDLE. A seed offered then is not consumed.
- gen_count holds its final value until the next seed accept.
- Reset mid-job aborts immediately to reset values; no output is produced.
- out_data equals cells in every state. out_valid qualifies it.

Optional Feature:
Macro WOLFRAM_CA_TRACE_EN.
- Defined: every generation is streamed.
  - After the seed is accepted, the engine first presents generation 0 (the seed). In RUN it presents each newly computed row with out_valid=1, out_last=0.
  - The engine advances to the next generation only on an out_ready handshake; it stalls with data stable otherwise.
  - The final row has out_last=1. A job therefore produces seed_gens+1 beats.
- Undefined: only the final row is presented (single beat, out_last=1), as described above.

Decomposition:
- Package wolfram_ca_pkg holds:
  - the state enum (IDLE/RUN/OUT);
  - rule-index bit-position constants (L=2, C=1, R=0);
  - a function rule_lookup(rule, l, c, r).
- Sub-module wolfram_ca_row_next (combinational: row, rule in, next row out; boundary set by PERIODIC) is natural. It is instantiated once.

Test Plan:
- Rule reset check: WIDTH=8, PERIODIC=1, no rule write, seed 8'h01, gens=1 -> out_data=8'h03, out_valid at accept+2 cycles, gen_count=1.
- Rule 30 case: cfg_rule=8'h1E, PERIODIC=0, seed 8'h10, gens=2 -> 8'h64. Gens=0 with seed 8'hA5 -> 8'hA5 at accept+1 cycle.
- Rule 90 boundaries: cfg_rule=8'h5A, seed 8'h80, gens=1 -> 8'h40 with PERIODIC=0 and 8'h41 with PERIODIC=1. Seed 8'h10 -> 8'h28 in both.
- Backpressure and busy drops:
  - Hold out_ready=0 for 5 cycles in OUT -> out_data/out_valid stable, seed_ready=0.
  - Offer a seed while busy -> not accepted.
  - cfg_rule_we while busy -> rule unchanged for the next job.
- Reset mid-RUN: gens=200, assert rst_n=0 at cycle 50 -> all outputs at reset values asynchronously, rule=RULE_DEFAULT, next job correct.
- Trace mode, with WOLFRAM_CA_TRACE_EN: rule 30, seed 8'h10, gens=2, random out_ready -> beats 8'h10, 8'h38, 8'h64; out_last only on the third beat; no beat lost or duplicated.
